ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address/PC width.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pc  input  WIDTH  current PC from the PC register, stable while fetch is outstanding.
REQ-005 SHALL have port pc_update  input  1  pulse: PC register advances on this edge; next fetch starts.
REQ-006 SHALL have ports ar_valid out 1, ar_addr out WIDTH, ar_ready in 1  read-address channel.
REQ-007 SHALL have ports r_valid in 1, r_data in 32, r_resp in 2, r_ready out 1  read-data channel.
REQ-008 SHALL have ports inst_valid out 1, inst out 32, inst_pc out WIDTH, inst_ready in 1  decode-side handshake.
REQ-009 SHALL have port fetch_fault  output  1  qualifies inst: misaligned PC or bus error.

Function
REQ-010 SHALL implement FSM states IDLE, ADDR, DATA, OUT.
REQ-011 ADDR: ar_valid=1, ar_addr=pc; ar_valid SHALL NOT drop until ar_valid&ar_ready; on handshake -> DATA.
REQ-012 ADDR with pc[1:0]!=0: no bus request (ar_valid=0), latch inst=0, inst_pc=pc, fetch_fault=1, -> OUT next cycle.
REQ-013 DATA: r_ready=1; on r_valid latch inst=r_data, inst_pc=pc, fetch_fault=(r_resp!=2'b00) -> OUT; on fault, inst SHALL be 0.
REQ-014 OUT: inst_valid=1, inst/inst_pc/fetch_fault held stable until inst_valid&inst_ready; then -> IDLE.
REQ-015 IDLE: all handshake outputs 0; pc_update -> ADDR (pc input then holds the new PC).
REQ-016 pc_update outside IDLE SHALL be ignored; no state change.
REQ-017 r_valid outside DATA and ar_ready outside ADDR SHALL be ignored.
REQ-018 ar_ready and r_valid in the same cycle while in ADDR: only address handshake taken; data accepted in DATA from next cycle.
REQ-019 Minimum latency pc_update -> inst_valid: 3 cycles with zero-wait memory (ADDR, DATA, OUT).
REQ-020 Exactly one outstanding read at any time; no pipelining of fetches.
REQ-021 ar_valid, r_ready, inst_valid SHALL be decoded from registered state only (no combinational path from inputs).

Reset
REQ-022 While rst=1: ar_valid=0, r_ready=0, inst_valid=0, fetch_fault=0, inst=0, inst_pc=0.
REQ-023 Reset SHALL load state ADDR so the first fetch (PC reset value 0x80000000) issues the cycle after rst falls, with no pc_update.
REQ-024 rst asserted mid-transaction SHALL abandon it; a late r_valid after reset (state ADDR) SHALL be ignored.

Structure
REQ-025 Shared package SHALL hold ifu_state_t enum (IDLE, ADDR, DATA, OUT) and RESP_OKAY=2'b00.
REQ-026 No sub-module; single FSM plus output registers.

Verification
REQ-027 Reset release, pc=0x80000000, ar_ready=1, r_valid next cycle with r_data=0x00000413 -> inst_valid on 3rd cycle after reset, inst=0x00000413, inst_pc=0x80000000, fetch_fault=0.
REQ-028 ar_ready held low 5 cycles -> ar_valid stays 1 with ar_addr=0x80000000 throughout; single handshake on cycle 6.
REQ-029 pc=0x80000002 after pc_update -> no ar_valid; inst_valid with inst=0, fetch_fault=1, inst_pc=0x80000002.
REQ-030 r_resp=2'b10, r_data=0xDEADBEEF -> inst=0, fetch_fault=1.
REQ-031 inst_ready low 4 cycles in OUT, pc_update pulsed meanwhile -> outputs stable, pulse ignored, IDLE after handshake, no new ar_valid.
REQ-032 rst asserted in DATA, stale r_valid the cycle after release -> not accepted; fresh ar_valid for 0x80000000 issued.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;

    // Fetch sequencer states: wait for PC, address phase, data phase, hand to decode.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        OUT  = 2'd3
    } ifu_state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding read at a time.
// IDLE -> ADDR -> DATA -> OUT -> IDLE. A misaligned PC skips the bus entirely
// and goes straight to OUT with a fault-qualified zero instruction.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    input  logic             pc_update,
    output logic             ar_valid,
    output logic [WIDTH-1:0] ar_addr,
    input  logic             ar_ready,
    input  logic             r_valid,
    input  logic [31:0]      r_data,
    input  logic [1:0]       r_resp,
    output logic             r_ready,
    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [WIDTH-1:0] inst_pc,
    input  logic             inst_ready,
    output logic             fetch_fault
);

    ifu_state_t       r_state;
    ifu_state_t       w_state_nxt;
    logic [31:0]      r_inst;
    logic [WIDTH-1:0] r_inst_pc;
    logic             r_fault;
    logic             w_misaligned;
    logic             w_resp_ok;

    // pc comes straight from the PC register, so its low bits are a registered value.
    assign w_misaligned = (pc[1:0] != 2'b00);
    assign w_resp_ok    = (r_resp == RESP_OKAY);

    // State register; reset lands in ADDR so the reset PC is fetched without a pc_update.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ADDR;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode; each state only looks at its own handshake inputs.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (pc_update)  w_state_nxt = ADDR;
            ADDR: begin
                if (w_misaligned)  w_state_nxt = OUT;
                else if (ar_ready) w_state_nxt = DATA;
            end
            DATA: if (r_valid)    w_state_nxt = OUT;
            OUT:  if (inst_ready) w_state_nxt = IDLE;
            default:              w_state_nxt = ADDR;
        endcase
    end

    // Capture the instruction, its PC and the fault flag; held untouched through OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_fault   <= 1'b0;
        end else if (r_state == ADDR && w_misaligned) begin
            r_inst    <= '0;
            r_inst_pc <= pc;
            r_fault   <= 1'b1;
        end else if (r_state == DATA && r_valid) begin
            r_inst    <= w_resp_ok ? r_data : 32'h0;
            r_inst_pc <= pc;
            r_fault   <= ~w_resp_ok;
        end
    end

    // Output decode from state; everything is forced quiet while rst is held.
    always_comb begin
        ar_valid    = 1'b0;
        ar_addr     = '0;
        r_ready     = 1'b0;
        inst_valid  = 1'b0;
        inst        = '0;
        inst_pc     = '0;
        fetch_fault = 1'b0;
        if (!rst) begin
            ar_valid    = (r_state == ADDR) && !w_misaligned;
            ar_addr     = (r_state == ADDR) ? pc : '0;
            r_ready     = (r_state == DATA);
            inst_valid  = (r_state == OUT);
            inst        = r_inst;
            inst_pc     = r_inst_pc;
            fetch_fault = r_fault;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reset, normal fetch, address stall,
// misaligned PC, bus error, decode back-pressure and mid-transaction reset.
module tb_ifu_fetch;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] pc;
    logic             pc_update;
    logic             ar_valid;
    logic [WIDTH-1:0] ar_addr;
    logic             ar_ready;
    logic             r_valid;
    logic [31:0]      r_data;
    logic [1:0]       r_resp;
    logic             r_ready;
    logic             inst_valid;
    logic [31:0]      inst;
    logic [WIDTH-1:0] inst_pc;
    logic             inst_ready;
    logic             fetch_fault;

    int n_chk  = 0;
    int n_pass = 0;

    ifu_fetch #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_update  (pc_update),
        .ar_valid   (ar_valid),
        .ar_addr    (ar_addr),
        .ar_ready   (ar_ready),
        .r_valid    (r_valid),
        .r_data     (r_data),
        .r_resp     (r_resp),
        .r_ready    (r_ready),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse pc_update from IDLE; the PC register takes the new value on that edge.
    task automatic start_fetch(input logic [WIDTH-1:0] new_pc);
        pc_update = 1'b1;
        tick();
        pc_update = 1'b0;
        pc        = new_pc;
    endtask

    task automatic retire();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc = 32'h8000_0000; pc_update = 1'b0;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00; inst_ready = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_ar_valid",   ar_valid,    0);
        chk("rst_r_ready",    r_ready,     0);
        chk("rst_inst_valid", inst_valid,  0);
        chk("rst_fault",      fetch_fault, 0);
        chk("rst_inst",       inst,        0);
        chk("rst_inst_pc",    inst_pc,     0);

        // Boot fetch with zero-wait memory: ADDR, DATA, OUT
        rst = 1'b0; ar_ready = 1'b1;
        #1;
        chk("boot_ar_valid", ar_valid, 1);
        chk("boot_ar_addr",  ar_addr,  32'h8000_0000);
        tick();
        ar_ready = 1'b0; r_valid = 1'b1; r_data = 32'h0000_0413; r_resp = 2'b00;
        #1;
        chk("boot_r_ready",  r_ready,  1);
        chk("boot_ar_drop",  ar_valid, 0);
        tick();
        r_valid = 1'b0;
        chk("boot_inst_valid", inst_valid,  1);
        chk("boot_inst",       inst,        32'h0000_0413);
        chk("boot_inst_pc",    inst_pc,     32'h8000_0000);
        chk("boot_fault",      fetch_fault, 0);
        retire();
        chk("boot_idle_iv", inst_valid, 0);
        chk("boot_idle_ar", ar_valid,   0);

        // Address stall: ar_ready low 5 cycles, r_valid alongside the address handshake
        start_fetch(32'h8000_0000);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_ar_valid_%0d", i), ar_valid, 1);
            chk($sformatf("stall_ar_addr_%0d", i),  ar_addr,  32'h8000_0000);
            tick();
        end
        ar_ready = 1'b1; r_valid = 1'b1; r_data = 32'h0BAD_0BAD;
        #1;
        chk("stall_hs_ar_valid", ar_valid, 1);
        tick();
        ar_ready = 1'b0; r_valid = 1'b0;
        chk("stall_single_hs", ar_valid,   0);
        chk("stall_in_data",   r_ready,    1);
        tick();
        chk("stall_no_early_data", inst_valid, 0);
        chk("stall_still_data",    r_ready,    1);
        r_valid = 1'b1; r_data = 32'h1234_5678;
        tick();
        r_valid = 1'b0;
        chk("stall_inst_valid", inst_valid, 1);
        chk("stall_inst",       inst,       32'h1234_5678);
        retire();

        // Misaligned PC: no bus request, faulted zero instruction
        start_fetch(32'h8000_0002);
        #1;
        chk("mis_no_ar", ar_valid, 0);
        tick();
        chk("mis_inst_valid", inst_valid,  1);
        chk("mis_inst",       inst,        0);
        chk("mis_fault",      fetch_fault, 1);
        chk("mis_inst_pc",    inst_pc,     32'h8000_0002);
        retire();

        // Bus error response
        start_fetch(32'h8000_0004);
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0; r_valid = 1'b1; r_data = 32'hDEAD_BEEF; r_resp = 2'b10;
        tick();
        r_valid = 1'b0; r_resp = 2'b00;
        chk("err_inst_valid", inst_valid,  1);
        chk("err_inst",       inst,        0);
        chk("err_fault",      fetch_fault, 1);
        chk("err_inst_pc",    inst_pc,     32'h8000_0004);
        retire();
        chk("err_fault_cleared_next", inst_valid, 0);

        // Decode back-pressure with a stray pc_update in OUT
        start_fetch(32'h8000_0008);
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0; r_valid = 1'b1; r_data = 32'hCAFE_F00D;
        tick();
        r_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc_update = (i == 1);
            chk($sformatf("bp_iv_%0d", i),   inst_valid,  1);
            chk($sformatf("bp_inst_%0d", i), inst,        32'hCAFE_F00D);
            chk($sformatf("bp_pc_%0d", i),   inst_pc,     32'h8000_0008);
            chk($sformatf("bp_flt_%0d", i),  fetch_fault, 0);
            chk($sformatf("bp_ar_%0d", i),   ar_valid,    0);
            tick();
        end
        pc_update = 1'b0;
        retire();
        chk("bp_idle_iv", inst_valid, 0);
        chk("bp_idle_ar", ar_valid,   0);
        tick();
        chk("bp_no_new_ar", ar_valid, 0);

        // Reset during DATA, stale r_valid after release
        start_fetch(32'h8000_000C);
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        chk("mid_in_data", r_ready, 1);
        rst = 1'b1; pc = 32'h8000_0000;
        tick();
        chk("mid_rst_ar", ar_valid,   0);
        chk("mid_rst_rr", r_ready,    0);
        chk("mid_rst_iv", inst_valid, 0);
        rst = 1'b0; r_valid = 1'b1; r_data = 32'h0000_0055;
        #1;
        chk("mid_fresh_ar",   ar_valid, 1);
        chk("mid_fresh_addr", ar_addr,  32'h8000_0000);
        chk("mid_stale_rr",   r_ready,  0);
        tick();
        r_valid = 1'b0;
        chk("mid_stale_ignored", ar_valid,   1);
        chk("mid_no_iv",         inst_valid, 0);
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0; r_valid = 1'b1; r_data = 32'h0000_0013;
        tick();
        r_valid = 1'b0;
        chk("mid_inst_valid", inst_valid, 1);
        chk("mid_inst",       inst,       32'h0000_0013);
        chk("mid_inst_pc",    inst_pc,    32'h8000_0000);
        retire();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
